// File: rtl/spi_ram_burst_if.sv
// Command/response bus between the SPI slave deserialiser and the burst RAM.
interface spi_ram_burst_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              ovf;

  modport master (
    output din, rx_valid, tx_ready,
    input  dout, tx_valid, ovf
  );

  modport slave (
    input  din, rx_valid, tx_ready,
    output dout, tx_valid, ovf
  );
endinterface

// File: rtl/spi_ram_burst.sv
// Single-port RAM behind the SPI deserialiser: 2-bit opcode commands set and
// auto-increment write/read pointers; read data leaves via valid/ready with a sticky overrun.
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_ram_burst_if.slave bus
);
  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] dout_q;
  logic              tx_valid_q;
  logic              ovf_q;
  logic [1:0]        op;
  logic [DATA_W-1:0] payload;
  logic              xfer;
  logic              rd_req;
  logic              rd_accept;

  // Payload wider or narrower than the pointer: keep the low ADDR_W bits, then fold into range.
  function automatic logic [ADDR_W-1:0] fold_addr(input logic [DATA_W-1:0] p);
    logic [ADDR_W+DATA_W-1:0] wide;
    logic [31:0]              a;
    wide = {{ADDR_W{1'b0}}, p};
    a    = 32'(wide[ADDR_W-1:0]);
    return ADDR_W'(a % 32'(MEM_DEPTH));
  endfunction

  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == LAST) ? '0 : p + ADDR_W'(1);
  endfunction

  assign op        = bus.din[DATA_W+1:DATA_W];
  assign payload   = bus.din[DATA_W-1:0];
  assign xfer      = tx_valid_q && bus.tx_ready;
  assign rd_req    = bus.rx_valid && (op == OP_READ);
  assign rd_accept = rd_req && (!tx_valid_q || bus.tx_ready);

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.ovf      = ovf_q;

  // Storage is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (bus.rx_valid && (op == OP_WDATA))
      mem[wr_ptr] <= payload;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (xfer)
        tx_valid_q <= 1'b0;
      if (bus.rx_valid) begin
        case (op)
          OP_WADDR: wr_ptr <= fold_addr(payload);
          OP_WDATA: if (AUTO_INC != 0) wr_ptr <= next_ptr(wr_ptr);
          OP_RADDR: rd_ptr <= fold_addr(payload);
          default: begin
            if (rd_accept) begin
              dout_q     <= mem[rd_ptr];
              tx_valid_q <= 1'b1;
              if (AUTO_INC != 0) rd_ptr <= next_ptr(rd_ptr);
            end else begin
              ovf_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: doc/spi_ram_burst.md
# spi_ram_burst

Parametrised single-port synchronous RAM sitting behind the SPI slave deserialiser, in the same place in the datapath as the current fixed 8-bit RAM. It decodes 2-bit command words from the SPI receive path into write-address, write-data, read-address and read-request operations. Both address pointers auto-increment with wrap-around, so multi-byte bursts need one address command. Read data is returned under a valid/ready handshake with back-pressure and a sticky overrun flag.

## Interface
- DATA_W, 8, data word width and memory word width
- ADDR_W, 8, address pointer width
- MEM_DEPTH, 256, number of words, 2 ≤ MEM_DEPTH ≤ 2**ADDR_W; need not be a power of two
- AUTO_INC, 1, 1 = pointers increment after each data access; 0 = pointers static

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- din  in  DATA_W+2  command word: din[DATA_W+1:DATA_W] = opcode, din[DATA_W-1:0] = payload
- rx_valid  in  1  din valid this cycle; one command consumed per cycle when high
- tx_ready  in  1  SPI transmit path accepts dout this cycle
- dout  out  DATA_W  read data
- tx_valid  out  1  dout holds unconsumed read data
- ovf  out  1  sticky: a read request was dropped because dout was still pending

## Operation
- Registered state: wr_ptr, rd_ptr (ADDR_W each), dout, tx_valid, ovf, mem[MEM_DEPTH]. Memory is not reset.
- Commands execute only when rx_valid=1. With rx_valid=0 no state changes except the handshake clear.
- Opcode 00 sets wr_ptr = payload[ADDR_W-1:0], reduced modulo MEM_DEPTH when the payload is ≥ MEM_DEPTH.
- Opcode 01 writes mem[wr_ptr] = payload. If AUTO_INC=1, wr_ptr then advances by 1, wrapping MEM_DEPTH-1 → 0.
- Opcode 10 sets rd_ptr = payload, with the same modulo rule as opcode 00.
- Opcode 11 is a read request, with the payload ignored.
  - Accepted when tx_valid=0, or when tx_valid=1 and tx_ready=1 in the same cycle.
  - On acceptance: dout = mem[rd_ptr] and tx_valid = 1. If AUTO_INC=1, rd_ptr advances with the same wrap rule.
  - Otherwise the request is dropped: dout, tx_valid and rd_ptr are unchanged and ovf is set to 1.
- Handshake: a transfer occurs in any cycle with tx_valid=1 and tx_ready=1. After it, tx_valid=0 unless an accepted read reloads dout in that same cycle.
- dout holds its value after a transfer until the next accepted read.
- ovf clears only on reset.
- Opcodes 00, 01 and 10 never touch dout, tx_valid or ovf.

## Timing
- Reset values, with rst_n low at a rising edge: dout=0, tx_valid=0, ovf=0, wr_ptr=0, rd_ptr=0.
- Reset mid-burst discards any pending tx data. Memory contents survive reset.
- Write latency: a data write at edge N is visible to a read request executed at edge N+1 or later.
- Read latency: a read request sampled at edge N gives dout/tx_valid valid after edge N (registered, 1 cycle).
- Back-to-back reads with tx_ready held high stream one word per cycle; tx_valid stays high throughout.
- Pointer changes take effect on the next command: opcode 10 at edge N followed by opcode 11 at edge N+1 reads the new address.
- Wrap: with MEM_DEPTH=200, a write at wr_ptr=199 leaves wr_ptr=0.
- With AUTO_INC=0 the pointers never change except via opcodes 00 and 10.

## Test plan
- Reset then idle: rst_n low 2 cycles → dout=0, tx_valid=0, ovf=0. Opcode 11 with tx_ready=1 → dout=mem[0].
- Burst write/read: 00/0x10, then 01 with 0xA1, 0xB2, 0xC3, then 10/0x10, then three 11s with tx_ready=1 → dout sequence A1, B2, C3 on consecutive cycles, tx_valid high for 3 cycles then low.
- Wrap: MEM_DEPTH=200. Write address 199, write 0x55 and 0x66, read from 199 twice → 0x55, 0x66, and mem[0]=0x66.
- Back-pressure: tx_ready=0, two 11 requests at rd_ptr=5 → dout=mem[5], tx_valid stays 1, ovf=1, rd_ptr=6. Raise tx_ready for 1 cycle → tx_valid=0 next cycle.
- AUTO_INC=0: three 01 writes of 0x11, 0x22, 0x33 at address 7 → mem[7]=0x33. Repeated reads at address 7 all return 0x33.
- Reset mid-stream: tx_valid=1 and ovf=1, pulse rst_n low → all outputs 0 and pointers 0, with the previously written data still readable.
